// File: rtl/instr_field_queue.sv
// Two-entry instruction queue between fetch and decode; presents the head word split into op/rd/rs/imm4.
// Optional stall counter on the head entry is compiled in with IFQ_STALL_CNT_EN.
`timescale 1ns/1ps
module instr_field_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [3:0]       out_op,
  output logic [3:0]       out_rd,
  output logic [3:0]       out_rs,
  output logic [3:0]       out_imm4
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high
  // and flush is low; ready never depends on the opposite side's valid/ready.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  end

  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_op   = out_valid ? head[15:12] : 4'h0;
  assign out_rd   = out_valid ? head[11:8]  : 4'h0;
  assign out_rs   = out_valid ? head[7:4]   : 4'h0;
  assign out_imm4 = out_valid ? head[3:0]   : 4'h0;

`ifdef IFQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'h0000;
    end else if (flush) begin
      stall_cycles <= 16'h0000;
    end else if (out_valid && !out_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_field_queue.sv
// Directed bench for instr_field_queue: reset, single word, fill, streaming wrap, flush, async reset.
// Stall counter steps run only when IFQ_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module tb_instr_field_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic [3:0]  out_imm4;
`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  instr_field_queue #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_rd(out_rd), .out_rs(out_rs), .out_imm4(out_imm4)
`ifdef IFQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1ns later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] head_word();
    return {out_op, out_rd, out_rs, out_imm4};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_fields", {16'd0, head_word()}, 32'd0);
    check("rst_pc", {16'd0, out_pc}, 32'd0);

    // Single word held with out_ready low
    in_valid = 1'b1; in_instr = 16'h312F; in_pc = 16'h0040;
    check("single_no_bypass", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_op", {28'd0, out_op}, 32'h3);
    check("single_rd", {28'd0, out_rd}, 32'h1);
    check("single_rs", {28'd0, out_rs}, 32'h2);
    check("single_imm4", {28'd0, out_imm4}, 32'hF);
    check("single_pc", {16'd0, out_pc}, 32'h0040);
    for (int i = 0; i < 5; i++) begin
      step();
      check("single_hold", {15'd0, out_valid, head_word()}, {15'd0, 1'b1, 16'h312F});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_empty", {31'd0, out_valid}, 32'd0);

    // Fill to two entries, third word refused
    in_valid = 1'b1; in_instr = 16'hA001; in_pc = 16'h0100;
    step();
    in_instr = 16'hB002; in_pc = 16'h0102;
    check("fill_ready_one", {31'd0, in_ready}, 32'd1);
    step();
    check("fill_full_ready", {31'd0, in_ready}, 32'd0);
    in_instr = 16'hC003; in_pc = 16'h0104;
    step();
    in_valid = 1'b0;
    check("fill_still_full", {31'd0, in_ready}, 32'd0);
    check("fill_head_a", {head_word(), out_pc}, {16'hA001, 16'h0100});
    out_ready = 1'b1;
    step();
    check("fill_head_b", {head_word(), out_pc}, {16'hB002, 16'h0102});
    check("fill_freed_slot", {31'd0, in_ready}, 32'd1);
    step();
    out_ready = 1'b0;
    check("fill_drained", {31'd0, out_valid}, 32'd0);

    // Streaming through wrapping pointers
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = (i < 7) ? 16'((i + 1) * 16'h1000) : 16'hF00F;
      in_pc    = 16'(16'h0200 + 2 * i);
      if (i == 0) begin
        check("stream_latency", {31'd0, out_valid}, 32'd0);
      end else begin
        check("stream_word", {15'd0, out_valid, head_word()}, {15'd0, 1'b1, 16'(i * 16'h1000)});
        check("stream_pc", {16'd0, out_pc}, {16'd0, 16'(16'h0200 + 2 * (i - 1))});
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_filler", {head_word(), out_pc}, {16'hF00F, 16'h020E});
    step();
    out_ready = 1'b0;
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Flush with two entries
    in_valid = 1'b1; in_instr = 16'hE001; in_pc = 16'h0300;
    step();
    in_instr = 16'hE002; in_pc = 16'h0302;
    step();
    flush = 1'b1; in_instr = 16'hD00D; in_pc = 16'h0304; out_ready = 1'b1;
    check("flush_head_before", {16'd0, head_word()}, {16'd0, 16'hE001});
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_empty", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_instr = 16'h5A5A; in_pc = 16'h0400;
    step();
    check("flush_next_push", {head_word(), out_pc}, {16'h5A5A, 16'h0400});
    // Flush with one entry: in_ready high but offered word dropped
    flush = 1'b1; in_instr = 16'hD00D; in_pc = 16'h0402;
    check("flush_ready_partial", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_drop_word", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges
    in_valid = 1'b1; in_instr = 16'h1234; in_pc = 16'h0500;
    step();
    in_valid = 1'b0;
    check("areset_pre", {15'd0, out_valid, head_word()}, {15'd0, 1'b1, 16'h1234});
    #2 reset = 1'b1;
    #1;
    check("areset_valid", {31'd0, out_valid}, 32'd0);
    check("areset_fields", {head_word(), out_pc}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("areset_ready", {31'd0, in_ready}, 32'd1);

`ifdef IFQ_STALL_CNT_EN
    check("stall_reset", {16'd0, stall_cycles}, 32'd0);
    in_valid = 1'b1; in_instr = 16'h7777; in_pc = 16'h0600;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall_ten", {16'd0, stall_cycles}, 32'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("stall_flush", {16'd0, stall_cycles}, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    check("stall_saturate", {16'd0, stall_cycles}, 32'h0000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_field_queue.md
Name: instr_field_queue

Overview:
- Two-entry instruction queue between instruction memory and the decode stage of the 16-bit datapath.
- Accepts fetched instruction words and their PC with a valid/ready handshake.
- Presents the head instruction split into opcode, rd, rs and the 4-bit immediate field.
- The imm4 output feeds the 4-to-16 sign extender directly; a flush input discards queued words on a taken branch or jump.

Parameters:
- WIDTH, 16, instruction word and PC width in bits; field slicing assumes 16.
- DEPTH, 2, number of queue entries; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch side has a word on in_instr/in_pc.
- in_ready  output  1  queue can accept a word this cycle.
- in_instr  input  WIDTH  fetched instruction word.
- in_pc  input  WIDTH  address of in_instr.
- flush  input  1  discard all queued entries.
- out_valid  output  1  head entry present.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  WIDTH  PC of head entry.
- out_op  output  4  head instr[15:12].
- out_rd  output  4  head instr[11:8].
- out_rs  output  4  head instr[7:4].
- out_imm4  output  4  head instr[3:0]; goes to the sign extender.
- stall_cycles  output  16  present only with IFQ_STALL_CNT_EN.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset state:
  - count=0, read and write pointers=0, out_valid=0.
  - All field outputs and out_pc=0.
  - in_ready=1 once reset deasserts.
  - Storage contents are don't-care.
- Flow control:
  - in_ready = (count < DEPTH). It is combinational from registered count only, never from out_ready; there is no full-queue pass-through.
  - Push = in_valid && in_ready && !flush. It writes {in_pc, in_instr} at wr_ptr, and wr_ptr increments modulo DEPTH.
  - Pop = out_valid && out_ready && !flush. rd_ptr increments modulo DEPTH.
- count update:
  - push and no pop: count+1.
  - pop and no push: count-1.
  - both: count unchanged.
  - Simultaneous push and pop is legal whenever 0 < count < DEPTH.
- out_valid = (count != 0). There is no bypass, so a word accepted in cycle N appears at the outputs in cycle N+1 at the earliest.
- Field outputs:
  - Combinational slices of the head storage entry when out_valid=1; forced to 0 when out_valid=0.
  - Outputs are stable while out_valid && !out_ready. The head is never changed by a push.
- Flush:
  - Highest priority. On the next edge count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop offered in the flush cycle is ignored and not counted as accepted.
  - in_ready stays asserted during flush if count < DEPTH. The fetch side must treat a word offered during flush as dropped.
- Boundaries:
  - Full (count=DEPTH): in_ready=0; a pop that cycle frees a slot for the following cycle.
  - Empty: out_ready is ignored.
  - Pointer wrap: from DEPTH-1 to 0.
  - Reset mid-operation: immediately returns every output to reset values, independent of clk.

Optional Feature:
- Macro: IFQ_STALL_CNT_EN.
- With the macro defined:
  - Adds the stall_cycles port, a 16-bit counter reset to 0.
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF and is cleared by flush.
- Without the macro: no stall_cycles port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-simulation between edges -> out_valid=0, out_op/rd/rs/imm4=0, out_pc=0 before the next clk edge; in_ready=1 after release.
- Single word: push in_instr=16'h312F, in_pc=16'h0040 with out_ready=0 -> next cycle out_valid=1, out_op=3, out_rd=1, out_rs=2, out_imm4=F, out_pc=16'h0040; holds for 5 cycles.
- Fill: push 16'hA001 then 16'hB002 with out_ready=0 -> count 2, in_ready=0; a third word 16'hC003 is not accepted; pops return A001 then B002 in order.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with words 0x1000..0x7000 stepping by 0x1000 plus one filler, pointers wrapping -> 7 words emitted in order, one per cycle after the 1-cycle initial latency, with no duplicates or drops.
- Flush with two entries: push two words, assert flush together with in_valid=1 (word 16'hD00D) and out_ready=1 -> next cycle out_valid=0, count=0; D00D never appears; the next push appears after 1 cycle.
- Stall counter (IFQ_STALL_CNT_EN): hold one entry with out_ready=0 for 10 cycles -> stall_cycles=10; flush -> 0; forced 70000-cycle stall -> stall_cycles saturates at 16'hFFFF.
